// File: rtl/fm7_audio_pkg.sv
// Shared constants and helpers for the FM-7 audio output stage.
// Derived counts are functions so the top can evaluate them for any parameter set.
package fm7_audio_pkg;

   localparam int BEEP_CONT_BIT = 0;
   localparam int BEEP_SHOT_BIT = 6;

   function automatic int half_period_cycles(input int clk_hz, input int beep_hz);
      return clk_hz / (2 * beep_hz);
   endfunction

   // 64-bit product: BEEP_MS * CLK_HZ overflows 32 bits at the default clock.
   function automatic int shot_cycles(input int clk_hz, input int beep_ms);
      return int'((longint'(beep_ms) * longint'(clk_hz)) / longint'(1000));
   endfunction

   function automatic int acc_width(input int ref_hz, input int out_hz);
      return $clog2(longint'(ref_hz) + longint'(out_hz)) + 1;
   endfunction

   localparam int DEF_HALF_CYCLES = half_period_cycles(32000000, 1200);
   localparam int DEF_SHOT_CYCLES = shot_cycles(32000000, 205);
   localparam int DEF_ACC_WIDTH   = acc_width(32000000, 8 * 48000);

   function automatic logic signed [15:0] saturate16(input logic signed [16:0] v);
      if (v > 17'sd32767)
         return 16'sh7FFF;
      if (v < -17'sd32768)
         return 16'sh8000;
      return v[15:0];
   endfunction

endpackage

// File: rtl/fm7_audio_mix_tick_gen.sv
// Fractional-accumulator rate generator: one-cycle tick at OUT_HZ average from REF_HZ.
// Tick is registered, one cycle after the accumulator crosses; free-running, no backpressure.
module audio_tick_gen
   import fm7_audio_pkg::*;
#(
   parameter int REF_HZ = 32000000,
   parameter int OUT_HZ = 384000
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam int W = acc_width(REF_HZ, OUT_HZ);

   logic [W-1:0] acc;
   logic [W-1:0] sum;

   assign sum = acc + W'(OUT_HZ);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc  <= '0;
         tick <= 1'b0;
      end else if (sum >= W'(REF_HZ)) begin
         acc  <= sum - W'(REF_HZ);
         tick <= 1'b1;
      end else begin
         acc  <= sum;
         tick <= 1'b0;
      end
   end

endmodule

// File: rtl/fm7_audio_mix.sv
// FM-7 audio out: $FD03 beeper + PSG mix, IIR low-pass, decimated to a 16-bit stereo stream.
// Beeper and mix are same-cycle; samples update only on sample_stb_o; no backpressure.
module fm7_audio_mix
   import fm7_audio_pkg::*;
#(
   parameter int CLK_HZ    = 32000000,
   parameter int SAMPLE_HZ = 48000,
   parameter int BEEP_HZ   = 1200,
   parameter int BEEP_MS   = 205,
   parameter int BEEP_AMP  = 8192,
   parameter int LPF_SHIFT = 3
) (
   input  logic        CLKSYS,
   input  logic        RESET,
   input  logic [7:0]  MDATABUS_in,
   input  logic        WFD03En,
   input  logic [13:0] psg_mix_i,
   output logic [15:0] audio_l_o,
   output logic [15:0] audio_r_o,
   output logic        sample_stb_o,
   output logic        beep_active_o
);

   localparam int HALF = half_period_cycles(CLK_HZ, BEEP_HZ);
   localparam int SHOT = shot_cycles(CLK_HZ, BEEP_MS);
   localparam int SW   = $clog2(SHOT + 1);
   localparam int HW   = $clog2(HALF + 1);
   localparam int YW   = 16 + LPF_SHIFT;
   localparam logic signed [15:0] AMP_P = 16'(BEEP_AMP);
   localparam logic signed [15:0] AMP_N = 16'(-BEEP_AMP);

   logic                 beep_cont;
   logic [SW-1:0]        shot_cnt;
   logic                 beep_active;
   logic [HW-1:0]        half_cnt;
   logic                 tone_hi;
   logic signed [15:0]   beep_lvl;
   logic signed [15:0]   psg_s;
   logic signed [16:0]   mix_sum;
   logic signed [15:0]   mix_lvl;
   logic                 tick;
   logic signed [YW-1:0] y;
   logic signed [YW:0]   diff;
   logic signed [YW:0]   step;
   logic signed [YW-1:0] y_next;
   logic [2:0]           tick_cnt;
   logic                 unused_bits;

   assign beep_active   = beep_cont | (shot_cnt != '0);
   assign beep_active_o = beep_active;

   // A shot reload takes priority over the decrement, so expiry and rewrite never leave a gap.
   always_ff @(posedge CLKSYS or posedge RESET) begin
      if (RESET) begin
         beep_cont <= 1'b0;
         shot_cnt  <= '0;
      end else begin
         if (WFD03En)
            beep_cont <= MDATABUS_in[BEEP_CONT_BIT];
         if (WFD03En && MDATABUS_in[BEEP_SHOT_BIT])
            shot_cnt <= SW'(SHOT);
         else if (shot_cnt != '0)
            shot_cnt <= shot_cnt - 1'b1;
      end
   end

   always_ff @(posedge CLKSYS or posedge RESET) begin
      if (RESET) begin
         half_cnt <= '0;
         tone_hi  <= 1'b1;
      end else if (!beep_active) begin
         half_cnt <= '0;
         tone_hi  <= 1'b1;
      end else if (half_cnt == HW'(HALF - 1)) begin
         half_cnt <= '0;
         tone_hi  <= ~tone_hi;
      end else begin
         half_cnt <= half_cnt + 1'b1;
      end
   end

   assign beep_lvl = beep_active ? (tone_hi ? AMP_P : AMP_N) : 16'sd0;

   // {psg,2'b00} - 32768 flips the top bit; the >>>1 then duplicates it as sign.
   assign psg_s   = {~psg_mix_i[13], ~psg_mix_i[13], psg_mix_i[12:0], 1'b0};
   assign mix_sum = {psg_s[15], psg_s} + {beep_lvl[15], beep_lvl};
   assign mix_lvl = saturate16(mix_sum);

   audio_tick_gen #(
      .REF_HZ (CLK_HZ),
      .OUT_HZ (8 * SAMPLE_HZ)
   ) u_tick (
      .clk   (CLKSYS),
      .reset (RESET),
      .tick  (tick)
   );

   assign diff   = $signed({mix_lvl[15], mix_lvl, {LPF_SHIFT{1'b0}}}) - $signed({y[YW-1], y});
   assign step   = diff >>> LPF_SHIFT;
   assign y_next = y + step[YW-1:0];

   always_ff @(posedge CLKSYS or posedge RESET) begin
      if (RESET) begin
         y            <= '0;
         tick_cnt     <= '0;
         sample_stb_o <= 1'b0;
         audio_l_o    <= '0;
         audio_r_o    <= '0;
      end else begin
         sample_stb_o <= 1'b0;
         if (tick) begin
            y        <= y_next;
            tick_cnt <= tick_cnt + 1'b1;
            if (tick_cnt == 3'd7) begin
               sample_stb_o <= 1'b1;
               audio_l_o    <= y_next[YW-1:LPF_SHIFT];
               audio_r_o    <= y_next[YW-1:LPF_SHIFT];
            end
         end
      end
   end

   assign unused_bits = &{1'b0, MDATABUS_in, step[YW]};

endmodule

// File: tb/tb_fm7_audio_mix.sv
// Directed bench for fm7_audio_mix at a scaled clock (500 kHz) so beeps fit a short run.
// Shot = 5000 cycles, half-period = 208 cycles, 10.42 cycles per sample.
module tb_fm7_audio_mix;

   logic        CLKSYS = 1'b0;
   logic        RESET  = 1'b1;
   logic [7:0]  MDATABUS_in = 8'h00;
   logic        WFD03En = 1'b0;
   logic [13:0] psg_mix_i = 14'd8192;
   logic [15:0] audio_l_o;
   logic [15:0] audio_r_o;
   logic        sample_stb_o;
   logic        beep_active_o;

   int total = 0;
   int bad   = 0;

   fm7_audio_mix #(
      .CLK_HZ    (500000),
      .SAMPLE_HZ (48000),
      .BEEP_HZ   (1200),
      .BEEP_MS   (10),
      .BEEP_AMP  (20000),
      .LPF_SHIFT (3)
   ) dut (
      .CLKSYS        (CLKSYS),
      .RESET         (RESET),
      .MDATABUS_in   (MDATABUS_in),
      .WFD03En       (WFD03En),
      .psg_mix_i     (psg_mix_i),
      .audio_l_o     (audio_l_o),
      .audio_r_o     (audio_r_o),
      .sample_stb_o  (sample_stb_o),
      .beep_active_o (beep_active_o)
   );

   always #5 CLKSYS = ~CLKSYS;

   task automatic check(input string tag, input int obs, input int exp);
      total++;
      if (obs != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic wait_stb();
      int n = 0;
      @(negedge CLKSYS);
      while (!sample_stb_o && n < 100) begin
         n++;
         @(negedge CLKSYS);
      end
      if (!sample_stb_o)
         check("stb_timeout", 0, 1);
   endtask

   task automatic pulse_wr(input logic [7:0] d);
      MDATABUS_in = d;
      WFD03En     = 1'b1;
      @(negedge CLKSYS);
      WFD03En     = 1'b0;
   endtask

   // Counts cycles beep_active_o stays high; optional writes at given cycle numbers.
   task automatic shot_run(input int w1_at, input logic [7:0] w1_dat,
                           input int w2_at, input logic [7:0] w2_dat,
                           input bit tone_chk, output int cnt);
      cnt = 0;
      while (beep_active_o && cnt < 30000) begin
         if (tone_chk) begin
            if (cnt == 0)   check("tone_first", dut.beep_lvl, 20000);
            if (cnt == 207) check("tone_h207", dut.beep_lvl, 20000);
            if (cnt == 208) check("tone_l208", dut.beep_lvl, -20000);
            if (cnt == 416) check("tone_h416", dut.beep_lvl, 20000);
         end
         cnt++;
         WFD03En = 1'b0;
         if (cnt == w1_at) begin
            MDATABUS_in = w1_dat;
            WFD03En     = 1'b1;
         end else if (cnt == w2_at) begin
            MDATABUS_in = w2_dat;
            WFD03En     = 1'b1;
         end
         @(negedge CLKSYS);
      end
      WFD03En = 1'b0;
   endtask

   initial begin
      int cnt, mn, mx, last, gap_mn, gap_mx, nchg, nlr, nbad, a;
      logic [15:0] prev;

      // Reset state
      repeat (3) @(negedge CLKSYS);
      check("rst_l", audio_l_o, 0);
      check("rst_r", audio_r_o, 0);
      check("rst_stb", sample_stb_o, 0);
      check("rst_act", beep_active_o, 0);
      RESET = 1'b0;

      // Mid-scale PSG settles to zero
      repeat (8) wait_stb();
      a = $signed(audio_l_o);
      check("mid_l", (a >= -1 && a <= 1), 1);
      check("mid_r", audio_r_o, audio_l_o);
      check("mid_act", beep_active_o, 0);

      // Full-scale PSG converges to 16382 (floor truncation may leave it at 16381)
      psg_mix_i = 14'd16383;
      mn = 32767; mx = -32768;
      for (int i = 0; i < 150; i++) begin
         wait_stb();
         a = $signed(audio_l_o);
         if (a < mn) mn = a;
         if (a > mx) mx = a;
      end
      a = $signed(audio_l_o);
      check("conv_full", (a >= 16381 && a <= 16382), 1);
      check("no_overshoot", (mx <= 16382), 1);
      check("no_signflip", (mn >= 0), 1);

      // Strobe rate: 125-cycle period holds exactly 12 strobes
      psg_mix_i = 14'd0;
      cnt = 0; last = -1; gap_mn = 1000; gap_mx = 0; nchg = 0; nlr = 0;
      @(negedge CLKSYS);
      prev = audio_l_o;
      for (int c = 0; c < 12500; c++) begin
         @(negedge CLKSYS);
         if (sample_stb_o) begin
            if (last >= 0) begin
               if (c - last < gap_mn) gap_mn = c - last;
               if (c - last > gap_mx) gap_mx = c - last;
            end
            last = c;
            cnt++;
         end else if (audio_l_o != prev) begin
            nchg++;
         end
         if (audio_l_o != audio_r_o) nlr++;
         prev = audio_l_o;
      end
      check("stb_count", cnt, 1200);
      check("stb_gap_min", gap_mn, 10);
      check("stb_gap_max", gap_mx, 11);
      check("chg_no_stb", nchg, 0);
      check("l_ne_r", nlr, 0);
      check("conv_zero_psg", $signed(audio_l_o), -16384);

      // Single shot with tone phase
      psg_mix_i = 14'd8192;
      repeat (20) @(negedge CLKSYS);
      check("beep_idle", dut.beep_lvl, 0);
      pulse_wr(8'h40);
      shot_run(0, 8'h00, 0, 8'h00, 1'b1, cnt);
      check("shot_len", cnt, 5000);

      // Restart at 3000, 0x00 mid-shot ignored
      repeat (10) @(negedge CLKSYS);
      pulse_wr(8'h40);
      shot_run(3000, 8'h40, 5000, 8'h00, 1'b0, cnt);
      check("shot_restart", cnt, 8000);

      // Rewrite on the expiry cycle: no gap
      repeat (10) @(negedge CLKSYS);
      pulse_wr(8'h40);
      shot_run(5000, 8'h40, 0, 8'h00, 1'b0, cnt);
      check("shot_expiry_rewrite", cnt, 10000);

      // Continuous tone, saturation in both directions
      repeat (10) @(negedge CLKSYS);
      psg_mix_i = 14'd16383;
      pulse_wr(8'h01);
      check("cont_act", beep_active_o, 1);
      check("cont_beep_hi", dut.beep_lvl, 20000);
      check("sat_pos", dut.mix_lvl, 32767);
      repeat (208) @(negedge CLKSYS);
      check("cont_beep_lo", dut.beep_lvl, -20000);
      check("mix_nosat", dut.mix_lvl, -3618);
      psg_mix_i = 14'd0;
      #1;
      check("sat_neg", dut.mix_lvl, -32768);
      psg_mix_i = 14'd8192;
      repeat (6000) @(negedge CLKSYS);
      check("cont_long", beep_active_o, 1);

      // Asynchronous reset mid-tone
      #2 RESET = 1'b1;
      #1;
      check("arst_act", beep_active_o, 0);
      check("arst_l", audio_l_o, 0);
      check("arst_r", audio_r_o, 0);
      check("arst_stb", sample_stb_o, 0);
      check("arst_beep", dut.beep_lvl, 0);
      @(negedge CLKSYS);
      RESET = 1'b0;
      nbad = 0;
      for (int c = 0; c < 600; c++) begin
         @(negedge CLKSYS);
         if (beep_active_o || dut.beep_lvl != 0 || audio_l_o != 0 || audio_r_o != 0)
            nbad++;
      end
      check("post_rst_silent", nbad, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fm7_audio_mix.md
# fm7_audio_mix

Final audio stage of the FM-7 core. Consumes the 14-bit unsigned PSG mix from the sound block, synthesizes the FM-7 beeper controlled by writes to $FD03, and sums both into one signed level. The level is low-pass filtered and decimated into a 16-bit signed stereo sample stream (mono duplicated) with a sample strobe for the MiSTer audio output.

## Interface
Parameters:
- CLK_HZ, 32000000, CLKSYS frequency in Hz.
- SAMPLE_HZ, 48000, output sample rate.
- BEEP_HZ, 1200, beeper tone frequency.
- BEEP_MS, 205, single-shot beep length in ms.
- BEEP_AMP, 8192, beeper square amplitude (signed peak).
- LPF_SHIFT, 3, IIR coefficient as 2^-LPF_SHIFT.

Ports:
- CLKSYS  in  1  system clock; the only clock.
- RESET  in  1  asynchronous, active-high reset.
- MDATABUS_in  in  8  CPU write data.
- WFD03En  in  1  one-cycle write strobe for $FD03, synchronous to CLKSYS.
- psg_mix_i  in  14  unsigned PSG mix.
- audio_l_o  out  16  signed sample, left.
- audio_r_o  out  16  signed sample, right (equals left).
- sample_stb_o  out  1  one-cycle pulse at SAMPLE_HZ average rate; the outputs change only on this pulse.
- beep_active_o  out  1  beeper currently sounding.

## Operation
- Beeper control on WFD03En:
  - bit0 latches `beep_cont`.
  - bit6=1 loads the single-shot counter with BEEP_MS·CLK_HZ/1000 cycles and starts it. Re-writing during a run restarts it from full.
  - bit6=0 never cancels a running shot.
- `beep_active` = `beep_cont` OR shot running.
- Shot counter decrements every cycle and stops at 0.
- Tone generator, active only while `beep_active`:
  - Half-period counter of CLK_HZ/(2·BEEP_HZ) cycles, integer-truncated.
  - First half-period is high (+BEEP_AMP), then alternates with −BEEP_AMP.
  - While inactive, the counter is held at 0 and the phase is reset to high, so every activation starts high. Beep contribution is 0.
- Level computation:
  - psg_s = {psg_mix_i,2'b00} − 32768, 16-bit signed, then arithmetic >>>1. Range −16384..+16382.
  - mix = psg_s + beep; saturate to −32768..32767.
- Filter tick:
  - Fractional accumulator of 8·SAMPLE_HZ against CLK_HZ.
  - Each cycle: acc += 8·SAMPLE_HZ. If acc ≥ CLK_HZ then acc −= CLK_HZ and assert `tick`.
- IIR, 16+LPF_SHIFT bit signed state y. On each `tick`: y += (mix<<LPF_SHIFT − y) >>> LPF_SHIFT. The output value is the top 16 bits of y.
- Decimation:
  - Every 8th tick (3-bit counter wrapping 7→0) asserts sample_stb_o.
  - On that tick, audio_l_o/audio_r_o load the filter output, computed after that tick's update.

## Timing
- Reset (async assert, sync release): `beep_cont`=0, shot counter=0, tone phase high with counter 0, acc=0, y=0, tick counter=0. All outputs are 0: audio_l_o, audio_r_o, sample_stb_o, beep_active_o.
- RESET mid-beep silences the beeper immediately. Audio outputs become 0 asynchronously.
- beep_active_o rises on the clock edge following the WFD03En cycle; the tone contributes from that same cycle.
- Shot expiry: beep_active_o falls the cycle after the counter reaches 0, unless `beep_cont`=1.
- Simultaneous shot expiry and a bit6 write: the reload wins, with no gap in beep_active_o.
- Simultaneous writes are not possible, since there is a single strobe.
- sample_stb_o spacing: floor or ceil of CLK_HZ/SAMPLE_HZ cycles, exactly SAMPLE_HZ pulses per CLK_HZ cycles.
- Sample latency: mix to output is at most one tick plus 8 ticks; there is no additional pipeline.
- psg_mix_i is sampled every cycle; no handshake.

## Structure
- Package fm7_audio_pkg:
  - derived localparams: half-period count, shot count, accumulator width.
  - $FD03 bit positions: BEEP_CONT_BIT=0, BEEP_SHOT_BIT=6.
  - saturate16 function.
- Sub-module audio_tick_gen: fractional-accumulator rate generator with parameters REF_HZ and OUT_HZ. It drives `tick`.
- Beeper control, tone, mixer, IIR and decimator live in the top module.

## Test plan
- Reset with psg_mix_i=8192 and no beep → after 8 ticks settled, audio_l_o=audio_r_o≈0 (within ±1); beep_active_o=0.
- psg_mix_i=16383 held → filter converges to 16382 within 150 samples, with no overshoot or sign flip.
- Write $FD03=0x40 at default params → beep_active_o high for exactly 6,560,000 cycles. Tone toggles every 13,333 cycles, with first half +8192.
- Write 0x40, then 0x40 again after 3,000,000 cycles → active for 9,560,000 cycles total with no low gap. Writing 0x00 mid-shot does not end it.
- Write 0x01 → continuous tone. Assert RESET mid-tone → all outputs 0 immediately, with no tone after release.
- Count sample_stb_o over 32,000,000 cycles → exactly 48,000 pulses, with spacing only 666 or 667 cycles.
